gzip_stream_sequencer: RTL and testbench

Sequences one complete GZIP member into the `word_merge64` bit packer. It emits the fixed 10-byte GZIP header, then the deflate block header (BFINAL=1, BTYPE=01 fixed Huffman), and passes Huffman codes from the encoder. After the last code it appends end-of-block, zero-pads to a byte boundary, and writes the CRC32/ISIZE trailer. It is the only writer of the word merge `in_*` port and sits between the LZ77/Huffman encoder and the word merge.

---
 rtl/gzip_stream_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_gzip_stream_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gzip_stream_sequencer.sv
// gzip_stream_sequencer
// Drives the word_merge64 in_* port with one complete GZIP member: the fixed
// 10-byte header, a fixed-Huffman deflate block header, the encoder's Huffman
// codes, end-of-block, zero padding to a byte boundary and the CRC32/ISIZE
// trailer. At most one write leaves per cycle, so no backpressure is needed.
// Optional feature: define GZSEQ_STATS_EN to add the stat_bits output.
module gzip_stream_sequencer #(
  parameter logic [7:0] HDR_OS  = 8'hFF,
  parameter logic [7:0] HDR_XFL = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        hc_valid,
  output logic        hc_ready,
  input  logic [5:0]  hc_size,
  input  logic [31:0] hc_data,
  input  logic        hc_last,
  input  logic        crc_valid,
  input  logic [31:0] crc_in,
  input  logic [31:0] isize_in,
  output logic        wm_valid,
  output logic        wm_last,
  output logic [5:0]  wm_size,
  output logic [31:0] wm_data,
  output logic        busy,
  output logic        done,
  output logic        err
`ifdef GZSEQ_STATS_EN
  ,
  output logic [31:0] stat_bits
`endif
);

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_HDR0   = 4'd1,
    ST_HDR1   = 4'd2,
    ST_HDR2   = 4'd3,
    ST_BLKHDR = 4'd4,
    ST_DATA   = 4'd5,
    ST_EOB    = 4'd6,
    ST_ALIGN  = 4'd7,
    ST_CRC    = 4'd8,
    ST_ISIZE  = 4'd9
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        wm_valid_q, wm_valid_d;
  logic        wm_last_q, wm_last_d;
  logic [5:0]  wm_size_q, wm_size_d;
  logic [31:0] wm_data_q, wm_data_d;
  logic [31:0] isize_q, isize_d;
  logic [2:0]  pad;

  // Codes are only taken while streaming the deflate body.
  assign hc_ready = (state_q == ST_DATA);

  // Zero bits needed to reach the next byte boundary: (8 - bitcnt) mod 8.
  assign pad = 3'd0 - bitcnt_q;

  // Next-state and next-write decode; at most one write is produced per state.
  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    isize_d    = isize_q;
    done_d     = 1'b0;
    wm_valid_d = 1'b0;
    wm_last_d  = 1'b0;
    wm_size_d  = 6'd0;
    wm_data_d  = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_HDR0;
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR0: begin
        // ID1=1F, ID2=8B, CM=08 (deflate), FLG=00
        wm_valid_d = 1'b1;
        wm_size_d  = 6'd32;
        wm_data_d  = 32'h00088B1F;
        state_d    = ST_HDR1;
      end
      ST_HDR1: begin
        // MTIME = 0
        wm_valid_d = 1'b1;
        wm_size_d  = 6'd32;
        wm_data_d  = 32'h00000000;
        state_d    = ST_HDR2;
      end
      ST_HDR2: begin
        wm_valid_d = 1'b1;
        wm_size_d  = 6'd16;
        wm_data_d  = {16'h0000, HDR_OS, HDR_XFL};
        state_d    = ST_BLKHDR;
      end
      ST_BLKHDR: begin
        // BFINAL=1 then BTYPE=01, LSB first
        wm_valid_d = 1'b1;
        wm_size_d  = 6'd3;
        wm_data_d  = 32'd3;
        state_d    = ST_DATA;
      end
      ST_DATA: begin
        if (hc_valid) begin
          if (hc_size > 6'd32) begin
            // oversize code is swallowed and flagged
            err_d = 1'b1;
          end else if (hc_size != 6'd0) begin
            wm_valid_d = 1'b1;
            wm_size_d  = hc_size;
            wm_data_d  = hc_data;
          end else begin
            wm_valid_d = 1'b0;
          end
          if (hc_last) begin
            state_d = ST_EOB;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_EOB: begin
        // fixed-Huffman literal 256 is seven zero bits
        wm_valid_d = 1'b1;
        wm_size_d  = 6'd7;
        wm_data_d  = 32'd0;
        state_d    = ST_ALIGN;
      end
      ST_ALIGN: begin
        if (pad != 3'd0) begin
          wm_valid_d = 1'b1;
          wm_size_d  = {3'b000, pad};
          wm_data_d  = 32'd0;
        end else begin
          wm_valid_d = 1'b0;
        end
        state_d = ST_CRC;
      end
      ST_CRC: begin
        if (crc_valid) begin
          wm_valid_d = 1'b1;
          wm_size_d  = 6'd32;
          wm_data_d  = crc_in;
          isize_d    = isize_in;
          state_d    = ST_ISIZE;
        end else begin
          state_d = ST_CRC;
        end
      end
      ST_ISIZE: begin
        wm_valid_d = 1'b1;
        wm_last_d  = 1'b1;
        wm_size_d  = 6'd32;
        wm_data_d  = isize_q;
        done_d     = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Bit position within the current byte, advanced by every write.
  always_comb begin
    if (state_q == ST_IDLE) begin
      bitcnt_d = 3'd0;
    end else if (wm_valid_d) begin
      bitcnt_d = bitcnt_q + wm_size_d[2:0];
    end else begin
      bitcnt_d = bitcnt_q;
    end
  end

  // Busy tracks the state being registered, so it is high outside IDLE.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and the registered word-merge outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      bitcnt_q   <= 3'd0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wm_valid_q <= 1'b0;
      wm_last_q  <= 1'b0;
      wm_size_q  <= 6'd0;
      wm_data_q  <= 32'd0;
      isize_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wm_valid_q <= wm_valid_d;
      wm_last_q  <= wm_last_d;
      wm_size_q  <= wm_size_d;
      wm_data_q  <= wm_data_d;
      isize_q    <= isize_d;
    end
  end

  assign wm_valid = wm_valid_q;
  assign wm_last  = wm_last_q;
  assign wm_size  = wm_size_q;
  assign wm_data  = wm_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

`ifdef GZSEQ_STATS_EN
  logic [31:0] stat_bits_q, stat_bits_d;

  // Total bits written in this member, padding included; holds after done.
  always_comb begin
    if ((state_q == ST_IDLE) && start) begin
      stat_bits_d = 32'd0;
    end else if (wm_valid_d) begin
      stat_bits_d = stat_bits_q + {26'd0, wm_size_d};
    end else begin
      stat_bits_d = stat_bits_q;
    end
  end

  // Statistics register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_bits_q <= 32'd0;
    end else begin
      stat_bits_q <= stat_bits_d;
    end
  end

  assign stat_bits = stat_bits_q;
`else
  // This build carries no statistics counter.
`endif

endmodule

// File: tb/tb_gzip_stream_sequencer.sv
// Bench for gzip_stream_sequencer: a cycle table for the two-code member,
// hand sequences for reset/abort, and randomized members checked against a
// write-list model built from the GZIP/deflate framing rules.
module tb_gzip_stream_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        hc_valid = 1'b0;
  logic        hc_ready;
  logic [5:0]  hc_size = 6'd0;
  logic [31:0] hc_data = 32'd0;
  logic        hc_last = 1'b0;
  logic        crc_valid = 1'b0;
  logic [31:0] crc_in = 32'd0;
  logic [31:0] isize_in = 32'd0;
  logic        wm_valid, wm_last, busy, done, err;
  logic [5:0]  wm_size;
  logic [31:0] wm_data;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  gzip_stream_sequencer dut (
    .clock(clock), .reset(reset), .start(start),
    .hc_valid(hc_valid), .hc_ready(hc_ready), .hc_size(hc_size),
    .hc_data(hc_data), .hc_last(hc_last),
    .crc_valid(crc_valid), .crc_in(crc_in), .isize_in(isize_in),
    .wm_valid(wm_valid), .wm_last(wm_last), .wm_size(wm_size),
    .wm_data(wm_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic        last;
    logic [5:0]  size;
    logic [31:0] data;
    logic        done;
    int          cyc;
  } wr_t;

  typedef struct {
    logic [5:0]  size;
    logic [31:0] data;
    logic        last;
  } code_t;

  typedef struct {
    logic        st, hv;
    logic [5:0]  hs;
    logic [31:0] hd;
    logic        hl, cv;
    logic [31:0] cr, isz;
    logic        ev, el;
    logic [5:0]  es;
    logic [31:0] ed;
    logic [3:0]  ectl; // {hc_ready, busy, done, err}
  } vec_t;

  wr_t   mon_q[$];
  wr_t   exp_q[$];
  code_t codes[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Capture every write; between writes the data path must be idle-zero.
  always @(negedge clock) begin
    wr_t w;
    if (wm_valid === 1'b1) begin
      w.last = wm_last; w.size = wm_size; w.data = wm_data; w.done = done; w.cyc = cyc;
      mon_q.push_back(w);
    end else begin
      check("idle_outputs_zero", {wm_last, done, wm_size, wm_data}, 64'd0);
    end
  end

  task automatic exp_push(input logic l, input logic [5:0] s, input logic [31:0] d);
    wr_t w;
    w.last = l; w.size = s; w.data = d; w.done = l; w.cyc = 0;
    exp_q.push_back(w);
  endtask

  function automatic vec_t mk(input logic st, input logic hv, input logic [5:0] hs,
                              input logic [31:0] hd, input logic hl, input logic cv,
                              input logic [31:0] cr, input logic [31:0] isz,
                              input logic ev, input logic el, input logic [5:0] es,
                              input logic [31:0] ed, input logic [3:0] ectl);
    vec_t v;
    v.st = st; v.hv = hv; v.hs = hs; v.hd = hd; v.hl = hl; v.cv = cv;
    v.cr = cr; v.isz = isz; v.ev = ev; v.el = el; v.es = es; v.ed = ed; v.ectl = ectl;
    return v;
  endfunction

  // Runs one member from the global code list and compares its writes.
  task automatic run_member(input int dly, input logic [31:0] crc, input logic [31:0] isz,
                            input logic pulse_start);
    int budget;
    int last_cyc;
    int rel_cyc;
    int start_cyc;
    int total;
    int pad;
    int n;
    int exp_crc_cyc;
    logic exp_err;
    mon_q.delete();
    exp_q.delete();
    // Model: framing rules applied to the code list.
    exp_err = 1'b0;
    exp_push(1'b0, 6'd32, 32'h00088B1F);
    exp_push(1'b0, 6'd32, 32'h00000000);
    exp_push(1'b0, 6'd16, 32'h0000FF00);
    exp_push(1'b0, 6'd3, 32'd3);
    total = 80 + 3;
    foreach (codes[i]) begin
      if (codes[i].size > 6'd32) exp_err = 1'b1;
      else if (codes[i].size != 6'd0) begin
        exp_push(1'b0, codes[i].size, codes[i].data);
        total += int'(codes[i].size);
      end
    end
    exp_push(1'b0, 6'd7, 32'd0);
    total += 7;
    pad = (8 - (total % 8)) % 8;
    if (pad != 0) exp_push(1'b0, 6'(pad), 32'd0);
    exp_push(1'b0, 6'd32, crc);
    exp_push(1'b1, 6'd32, isz);

    // Drive
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;
    check("start_clears_err", {63'd0, err}, 64'd0);
    check("busy_after_start", {63'd0, busy}, 64'd1);
    foreach (codes[i]) begin
      repeat ($urandom_range(0, 2)) begin
        hc_valid = 1'b0;
        tick();
      end
      hc_valid = 1'b1;
      hc_size  = codes[i].size;
      hc_data  = codes[i].data;
      hc_last  = codes[i].last;
      budget = 20;
      while (hc_ready !== 1'b1 && budget > 0) begin
        tick();
        budget--;
      end
      if (budget == 0) begin
        checks++; failures++;
        $display("FAIL hc_ready_timeout actual=0 expected=1");
      end
      tick();
    end
    hc_valid = 1'b0;
    hc_last  = 1'b0;
    last_cyc = cyc;
    for (int i = 0; i < dly; i++) begin
      start = (pulse_start && i == dly / 2) ? 1'b1 : 1'b0;
      tick();
      if (cyc >= last_cyc + 3) begin
        check("wait_no_write", {63'd0, wm_valid}, 64'd0);
        check("wait_busy", {63'd0, busy}, 64'd1);
      end
    end
    start = 1'b0;
    rel_cyc = cyc;
    crc_valid = 1'b1;
    crc_in = crc;
    isize_in = isz;
    budget = 50;
    while (done !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) begin
      checks++; failures++;
      $display("FAIL member_done_timeout actual=0 expected=1");
    end
    crc_valid = 1'b0;
    @(negedge clock);
    #1;

    // Compare
    check("write_count", 64'(mon_q.size()), 64'(exp_q.size()));
    n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("wr%0d_size", i), 64'(mon_q[i].size), 64'(exp_q[i].size));
      check($sformatf("wr%0d_data", i), 64'(mon_q[i].data), 64'(exp_q[i].data));
      check($sformatf("wr%0d_last_done", i), {62'd0, mon_q[i].last, mon_q[i].done},
            {62'd0, exp_q[i].last, exp_q[i].done});
    end
    if (n == exp_q.size() && n >= 6) begin
      check("hdr0_latency", 64'(mon_q[0].cyc), 64'(start_cyc + 1));
      check("hdr_consecutive", 64'(mon_q[3].cyc), 64'(start_cyc + 4));
      exp_crc_cyc = (rel_cyc + 1 > last_cyc + 3) ? rel_cyc + 1 : last_cyc + 3;
      check("crc_cycle", 64'(mon_q[n-2].cyc), 64'(exp_crc_cyc));
      check("isize_cycle", 64'(mon_q[n-1].cyc), 64'(exp_crc_cyc + 1));
    end
    check("err_end", {63'd0, err}, {63'd0, exp_err});
    check("idle_after_member", {62'd0, busy, hc_ready}, 64'd0);
  endtask

  task automatic add_code(input logic [5:0] s, input logic [31:0] d, input logic l);
    code_t c;
    c.size = s; c.data = d; c.last = l;
    codes.push_back(c);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[12];
    int ncodes;
    int r;
    logic [5:0] sz;

    // Reset state
    tick();
    check("reset_outputs", {56'd0, wm_valid, wm_last, busy, done, err, hc_ready, 2'b00}, 64'd0);
    check("reset_size_data", {26'd0, wm_size, wm_data}, 64'd0);
    reset = 1'b0;
    tick();

    // Two-code member, cycle by cycle
    tbl[0]  = mk(1,0,6'd0,32'd0,0,0,32'd0,32'd0,        0,0,6'd0,32'd0,           4'b0100);
    tbl[1]  = mk(0,0,6'd0,32'd0,0,0,32'd0,32'd0,        1,0,6'd32,32'h00088B1F,   4'b0100);
    tbl[2]  = mk(0,0,6'd0,32'd0,0,0,32'd0,32'd0,        1,0,6'd32,32'h00000000,   4'b0100);
    tbl[3]  = mk(0,0,6'd0,32'd0,0,0,32'd0,32'd0,        1,0,6'd16,32'h0000FF00,   4'b0100);
    tbl[4]  = mk(0,0,6'd0,32'd0,0,0,32'd0,32'd0,        1,0,6'd3,32'd3,           4'b1100);
    tbl[5]  = mk(0,1,6'd8,32'h8C,0,0,32'd0,32'd0,       1,0,6'd8,32'h8C,          4'b1100);
    tbl[6]  = mk(0,1,6'd9,32'h1A1,1,0,32'd0,32'd0,      1,0,6'd9,32'h1A1,         4'b0100);
    tbl[7]  = mk(0,0,6'd0,32'd0,0,0,32'd0,32'd0,        1,0,6'd7,32'd0,           4'b0100);
    tbl[8]  = mk(0,0,6'd0,32'd0,0,0,32'd0,32'd0,        1,0,6'd5,32'd0,           4'b0100);
    tbl[9]  = mk(0,0,6'd0,32'd0,0,1,32'hCBF43926,32'd9, 1,0,6'd32,32'hCBF43926,   4'b0100);
    tbl[10] = mk(0,0,6'd0,32'd0,0,0,32'd0,32'd0,        1,1,6'd32,32'd9,          4'b0010);
    tbl[11] = mk(0,0,6'd0,32'd0,0,0,32'd0,32'd0,        0,0,6'd0,32'd0,           4'b0000);
    for (int i = 0; i < 12; i++) begin
      start = tbl[i].st; hc_valid = tbl[i].hv; hc_size = tbl[i].hs; hc_data = tbl[i].hd;
      hc_last = tbl[i].hl; crc_valid = tbl[i].cv; crc_in = tbl[i].cr; isize_in = tbl[i].isz;
      tick();
      check($sformatf("tbl%0d_wm", i), {24'd0, wm_valid, wm_last, wm_size, wm_data},
            {24'd0, tbl[i].ev, tbl[i].el, tbl[i].es, tbl[i].ed});
      check($sformatf("tbl%0d_ctl", i), {60'd0, hc_ready, busy, done, err}, {60'd0, tbl[i].ectl});
    end

    // Empty stream: pad 6, CRC entered with crc_valid already high
    codes.delete();
    add_code(6'd0, 32'd0, 1'b1);
    run_member(0, 32'd0, 32'd0, 1'b0);

    // Aligned: 3+6+7 = 16 bits, so ALIGN writes nothing
    codes.delete();
    add_code(6'd6, 32'h2A, 1'b1);
    run_member(0, 32'h12345678, 32'd1, 1'b0);

    // Oversize code sets err; the member still completes
    codes.delete();
    add_code(6'd8, 32'h55, 1'b0);
    add_code(6'd40, 32'hDEADBEEF, 1'b0);
    add_code(6'd5, 32'h1F, 1'b1);
    run_member(1, 32'hA5A5A5A5, 32'd3, 1'b0);

    // Long crc_valid wait with an ignored start pulse (also clears err at entry)
    codes.delete();
    add_code(6'd13, 32'h1ABC, 1'b0);
    add_code(6'd32, 32'hFFFF0000, 1'b1);
    run_member(22, 32'h0BADF00D, 32'd77, 1'b1);

    // Reset in DATA aborts at once
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    check("abort_in_data", {63'd0, hc_ready}, 64'd1);
    hc_valid = 1'b1; hc_size = 6'd10; hc_data = 32'h3FF;
    tick();
    hc_valid = 1'b0;
    check("abort_code_written", {63'd0, wm_valid}, 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_outputs", {18'd0, wm_valid, wm_last, wm_size, wm_data, busy, done, err, hc_ready},
          64'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    mon_q.delete();
    repeat (10) tick();
    @(negedge clock);
    #1;
    check("no_write_after_abort", 64'(mon_q.size()), 64'd0);
    codes.delete();
    add_code(6'd11, 32'h7FF, 1'b1);
    run_member(0, 32'hCAFEF00D, 32'd2, 1'b0);

    // Randomized members
    for (int m = 0; m < 20; m++) begin
      codes.delete();
      ncodes = $urandom_range(1, 8);
      for (int k = 0; k < ncodes; k++) begin
        r = $urandom_range(0, 19);
        if (r == 0) sz = 6'd0;
        else if (r == 1) sz = 6'($urandom_range(33, 63));
        else sz = 6'($urandom_range(1, 32));
        add_code(sz, $urandom, (k == ncodes - 1) ? 1'b1 : 1'b0);
      end
      run_member($urandom_range(0, 4), $urandom, $urandom, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
